hazard_ctrl: RTL

//  Pipeline hazard unit for the 5-stage RV32I core; drives the clr/stall inputs of the stage

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32I pipeline: forwarding, load-use stall, branch flush,
// multi-cycle MUL/DIV hold, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MdStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdDone,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int MC_W = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [MC_W-1:0] r_mdcnt;
  logic [MC_W-1:0] w_mdcnt_next;
  logic            w_md_hold;
  logic            w_lw_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_mdcnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_mdcnt <= w_mdcnt_next;
    end
  end

  // MdStartE is ignored in BUSY: the same op is still sitting in Execute.
  always_comb begin
    w_state_next = r_state;
    w_mdcnt_next = r_mdcnt;
    case (r_state)
      IDLE: begin
        if (MdStartE) begin
          w_state_next = BUSY;
          w_mdcnt_next = MC_W'(MD_LAT - 2);
        end
      end
      BUSY: begin
        if (r_mdcnt != '0) begin
          w_mdcnt_next = r_mdcnt - 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_mdcnt_next = '0;
      end
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

    w_md_hold  = ((r_state == IDLE) && MdStartE) || ((r_state == BUSY) && (r_mdcnt != '0));
    // A taken branch squashes the wrong-path load-use, so no stall is needed.
    w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) &&
                 (r_state == IDLE) && !PCSrcE;

    StallF = w_lw_stall || w_md_hold;
    StallD = w_lw_stall || w_md_hold;
    StallE = w_md_hold;
    FlushM = w_md_hold;
    FlushD = PCSrcE;
    FlushE = (PCSrcE || w_lw_stall) && !w_md_hold;
    MdDone = (r_state == BUSY) && (r_mdcnt == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != {CNT_W{1'b1}})) StallCnt <= StallCnt + 1'b1;
      if (FlushD && (FlushCnt != {CNT_W{1'b1}})) FlushCnt <= FlushCnt + 1'b1;
    end
  end

endmodule
